// File: rtl/sram_rw_arbiter_if.sv
// Signal bundle between two requesters, sram_rw_arbiter and a single-port SRAM macro.
// Handshake: a requester holds req (with we/be/addr/wdata) until gnt is seen in the same
// cycle; the transfer happens in that cycle. A granted read returns rvalid/rdata exactly
// one cycle later, and rvalid carries no backpressure.
interface sram_rw_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  a_req_i;
    logic                  a_we_i;
    logic [NUM_WMASKS-1:0] a_be_i;
    logic [ADDR_WIDTH-1:0] a_addr_i;
    logic [DATA_WIDTH-1:0] a_wdata_i;
    logic                  a_gnt_o;
    logic                  a_rvalid_o;
    logic [DATA_WIDTH-1:0] a_rdata_o;

    logic                  b_req_i;
    logic                  b_we_i;
    logic [NUM_WMASKS-1:0] b_be_i;
    logic [ADDR_WIDTH-1:0] b_addr_i;
    logic [DATA_WIDTH-1:0] b_wdata_i;
    logic                  b_gnt_o;
    logic                  b_rvalid_o;
    logic [DATA_WIDTH-1:0] b_rdata_o;

    logic                  sram_csb_o;
    logic                  sram_web_o;
    logic [NUM_WMASKS-1:0] sram_wmask_o;
    logic [ADDR_WIDTH-1:0] sram_addr_o;
    logic [DATA_WIDTH-1:0] sram_din_o;
    logic [DATA_WIDTH-1:0] sram_dout_i;

    modport slave (
        input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        input  b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        input  sram_dout_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        output b_gnt_o, b_rvalid_o, b_rdata_o,
        output sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
    );

    modport master (
        output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
        output b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
        output sram_dout_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        input  b_gnt_o, b_rvalid_o, b_rdata_o,
        input  sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// Two-requester arbiter in front of port 0 of a single-port SRAM macro, read latency 1.
// Define RR_ARB_EN for round-robin contention; otherwise requester A has fixed priority.
module sram_rw_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sram_rw_arbiter_if.slave   bus
);
    logic a_win;
    logic b_win;
    logic win_we;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;   // 0 = A, 1 = B

`ifdef RR_ARB_EN
    logic ptr_q, ptr_d;             // 0 = A wins contention, 1 = B wins contention

    always_comb begin
        a_win = rst_ni & bus.a_req_i & (~bus.b_req_i | ~ptr_q);
        b_win = rst_ni & bus.b_req_i & (~bus.a_req_i | ptr_q);
        ptr_d = ptr_q;
        if (a_win) begin
            ptr_d = 1'b1;
        end else if (b_win) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        a_win = rst_ni & bus.a_req_i;
        b_win = rst_ni & bus.b_req_i & ~bus.a_req_i;
    end
`endif

    always_comb begin
        bus.sram_csb_o   = 1'b1;
        bus.sram_web_o   = 1'b1;
        bus.sram_wmask_o = '0;
        bus.sram_addr_o  = '0;
        bus.sram_din_o   = '0;
        win_we           = 1'b0;
        if (a_win) begin
            win_we           = bus.a_we_i;
            bus.sram_csb_o   = 1'b0;
            bus.sram_web_o   = ~bus.a_we_i;
            bus.sram_wmask_o = bus.a_we_i ? bus.a_be_i : '1;
            bus.sram_addr_o  = bus.a_addr_i;
            bus.sram_din_o   = bus.a_wdata_i;
        end else if (b_win) begin
            win_we           = bus.b_we_i;
            bus.sram_csb_o   = 1'b0;
            bus.sram_web_o   = ~bus.b_we_i;
            bus.sram_wmask_o = bus.b_we_i ? bus.b_be_i : '1;
            bus.sram_addr_o  = bus.b_addr_i;
            bus.sram_din_o   = bus.b_wdata_i;
        end
    end

    // The pending flag lives exactly one cycle; the owner only moves on a granted read.
    always_comb begin
        rd_pend_d  = (a_win | b_win) & ~win_we;
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = b_win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        bus.a_gnt_o    = a_win;
        bus.b_gnt_o    = b_win;
        bus.a_rvalid_o = rd_pend_q & ~rd_owner_q;
        bus.b_rvalid_o = rd_pend_q & rd_owner_q;
        bus.a_rdata_o  = bus.a_rvalid_o ? bus.sram_dout_i : '0;
        bus.b_rdata_o  = bus.b_rvalid_o ? bus.sram_dout_i : '0;
    end
endmodule

// File: doc/sram_rw_arbiter.md
SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane count (DATA_WIDTH/8).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports a_req_i/b_req_i, input, 1, requester A/B access request.
REQ-007 SHALL have ports a_we_i/b_we_i, input, 1, 1=write, 0=read.
REQ-008 SHALL have ports a_be_i/b_be_i, input, NUM_WMASKS, byte enables for writes.
REQ-009 SHALL have ports a_addr_i/b_addr_i, input, ADDR_WIDTH, word address.
REQ-010 SHALL have ports a_wdata_i/b_wdata_i, input, DATA_WIDTH, write data.
REQ-011 SHALL have ports a_gnt_o/b_gnt_o, output, 1, request accepted this cycle.
REQ-012 SHALL have ports a_rvalid_o/b_rvalid_o, output, 1, read data valid.
REQ-013 SHALL have ports a_rdata_o/b_rdata_o, output, DATA_WIDTH, read data.
REQ-014 SHALL have port sram_csb_o, output, 1, macro port-0 chip select, active low.
REQ-015 SHALL have port sram_web_o, output, 1, macro write enable, active low.
REQ-016 SHALL have ports sram_wmask_o (NUM_WMASKS), sram_addr_o (ADDR_WIDTH), sram_din_o (DATA_WIDTH), outputs, macro mask/address/data.
REQ-017 SHALL have port sram_dout_i, input, DATA_WIDTH, macro port-0 read data.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt asserted combinationally in the same cycle as req, and only when req high.
REQ-019 SHALL, in a granted cycle, drive sram_csb_o=0, sram_web_o=~we, sram_wmask_o=be on writes and all-ones on reads, addr/din from winner.
REQ-020 SHALL drive sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, addr/din=0 in cycles with no grant.
REQ-021 SHALL keep a 1-bit read-owner register plus read-pending flag, set on the clock edge ending a granted read cycle.
REQ-022 SHALL assert the owner's rvalid for exactly one cycle, the cycle after the grant (latency 1), with rdata = sram_dout_i; the non-owner rvalid SHALL be 0 and both rdata SHALL be 0 when their rvalid is 0.
REQ-023 SHALL produce no rvalid for granted writes.
REQ-024 SHALL sustain back-to-back grants every cycle, including read-after-write to the same address (written data returned, since the macro writes on the falling edge before the next read sample).
REQ-025 SHALL hold a priority pointer; with a single requester active, that requester is granted regardless of pointer.
REQ-026 SHALL never let a requester deassert req before gnt affect state; an ungranted request leaves all registers unchanged.

Reset
REQ-027 SHALL, while rst_ni=0, force both gnt=0, both rvalid=0, sram_csb_o=1, sram_web_o=1, owner/pending clear, priority pointer = A.
REQ-028 SHALL discard a read granted in the cycle reset asserts: no rvalid after reset release.
REQ-029 SHALL accept grants from the first rising edge after rst_ni deasserts.

Configuration
REQ-030 SHALL with RR_ARB_EN defined use round-robin: on a cycle where both request, grant the pointer's side and flip the pointer to the other side; single-requester grants also set pointer to the other side.
REQ-031 SHALL without RR_ARB_EN use fixed priority: A always wins contention; pointer logic absent.

Verification
REQ-032 SHALL cover: A write addr 0x005 data 0xDEADBEEF be 0xF, next cycle A read 0x005 -> a_gnt both cycles, a_rvalid one cycle later with a_rdata 0xDEADBEEF, b_rvalid 0.
REQ-033 SHALL cover: partial write be 0x2 data 0x0000AB00 over word 0x11223344 at 0x3FF -> later read returns 0x1122AB44.
REQ-034 SHALL cover: A and B both read every cycle for 6 cycles with RR_ARB_EN -> grants alternate A,B,A,B,A,B; without RR_ARB_EN -> A granted all 6, B never.
REQ-035 SHALL cover: B read granted, rst_ni pulled low mid-cycle -> csb high immediately, no b_rvalid after release, first post-reset contention grants A.
REQ-036 SHALL cover: no requests for 10 cycles -> sram_csb_o stays 1, no gnt, no rvalid.
